matrix_io_sequencer: RTL and testbench
======================================

Name: matrix_io_sequencer

Overview:
- Front/back-end sequencer around the 3x3 matrix multiply controller and its shared matrix memory.
- Accepts a byte stream of 18 elements: matrix A, then matrix B, each row-major. Writes them into memory, pulses the multiply via `mm_start`, and waits for `mm_done`.
- Then reads result matrix C from memory and streams its 9 elements out, row-major, over a valid/ready interface.
- Owns the memory bus except while the multiply controller runs; a top-level mux selects the bus owner from `bus_owner`.

Parameters:
- N, 3, matrix dimension. The controller is fixed at 3; only 3 is supported.
- DW, 8, element width in bits.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_data  in  DW  input element
- in_valid  in  1  in_data valid
- in_ready  out  1  sequencer accepts in_data this cycle
- out_data  out  DW  result element
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts out_data this cycle
- mm_start  out  1  start request to the multiply controller
- mm_done  in  1  done from the multiply controller (held high while it sits in DONE)
- bus_owner  out  1  1 = sequencer drives memory bus, 0 = multiply controller drives it
- matrix_select  out  2  memory bank: 0=A, 1=B, 2=C
- row  out  2  memory row address
- col  out  2  memory column address
- write_enable  out  1  memory write strobe
- write_data  out  DW  memory write data
- read_data  in  DW  memory read data, a combinational function of the current matrix_select/row/col
- frame_done  out  1  one-cycle pulse after the last C element is accepted

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports named clk and reset).
- Reset values:
  - in_ready=0, out_valid=0, out_data=0, mm_start=0, bus_owner=1.
  - matrix_select=0, row=0, col=0, write_enable=0, write_data=0, frame_done=0.
  - State=IDLE, all counters 0.
- All outputs are registered except in_ready, which is decoded from state: high in LOAD_A/LOAD_B only.
- States:
  - IDLE: go to LOAD_A next cycle. Clear row/col counters.
  - LOAD_A: on accept (in_valid && in_ready), next cycle write_enable=1, matrix_select=0, row/col = current counter, write_data = in_data. Counter advances col 0..2, then row+1. After the 9th accept, go to LOAD_B.
  - LOAD_B: same as LOAD_A with matrix_select=1. After the 9th accept, go to START.
  - In LOAD_A/LOAD_B, write_enable is 0 on any cycle following a non-accept cycle (in_valid gaps are tolerated).
  - START: bus_owner=0, mm_start=1. Move to WAIT_DONE next cycle. The last B write (write_enable pulse) completes before bus_owner falls; bus_owner falls the cycle after that write.
  - WAIT_DONE: hold mm_start=1 and bus_owner=0 until mm_done=1, then go to RELEASE.
  - RELEASE: mm_start=0. Stay exactly 2 cycles so the controller returns to IDLE, then bus_owner=1 and go to RD_ADDR.
  - RD_ADDR: matrix_select=2, row/col = read counter. Next state RD_DATA.
  - RD_DATA: capture read_data into out_data, set out_valid=1, go to OUT_HOLD.
  - OUT_HOLD: hold out_data/out_valid stable until out_ready. On the handshake cycle, out_valid drops next cycle and the counter advances.
    - After the 9th handshake: pulse frame_done for one cycle and go to IDLE.
    - Otherwise: go to RD_ADDR.
- Element throughput:
  - Load: 1 per cycle.
  - Readout: max 1 per 3 cycles.
- Arithmetic: C values are whatever the controller wrote (8-bit, mod-256). The sequencer performs no arithmetic beyond counter increments.
- Boundaries:
  - Counters wrap to 0 at each phase start.
  - in_valid during non-LOAD states is ignored (in_ready=0, no write).
  - mm_done high in any state other than WAIT_DONE is ignored.
  - out_ready high while out_valid=0 has no effect.
  - Reset mid-operation (any state): all outputs take reset values on the next edge, including mm_start=0, and a partial frame is discarded. The bench must also reset the controller in that case.

Test Plan:
- Identity: stream A=identity, B=1..9 with in_valid always 1 and out_ready always 1 -> out_data sequence 1,2,3,4,5,6,7,8,9, then one frame_done pulse; write_enable shows 18 pulses at A/B addresses row-major.
- Overflow: A=all 10, B=all 10 -> every C element 300 mod 256 = 44; 9 outputs of 44.
- Backpressure: A=B=all 1, out_ready toggling 1-of-3 cycles -> each out_data (value 3) held stable while out_valid=1 and out_ready=0; exactly 9 handshakes.
- Input gaps: in_valid low on alternate cycles -> no write_enable on gap cycles; memory contents identical to the gapless run; in_ready=0 in WAIT_DONE with in_valid=1 produces no writes.
- Bus handoff: check that bus_owner=0 from START through RELEASE. mm_start must fall on the cycle after mm_done is first seen high, and bus_owner must return to 1 exactly 2 cycles later. No sequencer write_enable may occur while bus_owner=0.
- Reset during WAIT_DONE: assert reset 1 cycle -> next edge mm_start=0, bus_owner=1, out_valid=0; a new 18-byte frame then completes correctly.

Source files
------------

// File: rtl/matrix_io_sequencer.sv
// Sequencer around the 3x3 matrix multiply controller: streams A and B into the
// shared matrix memory, starts the multiply, then streams C back out.
module matrix_io_sequencer #(
  parameter int N  = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          mm_start,
  input  logic          mm_done,
  output logic          bus_owner,
  output logic [1:0]    matrix_select,
  output logic [1:0]    row,
  output logic [1:0]    col,
  output logic          write_enable,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data,
  output logic          frame_done
);

  localparam logic [1:0] LAST = 2'(N - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT_DONE,
    S_RELEASE, S_RD_ADDR, S_RD_DATA, S_OUT_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      rc_q, rc_d, cc_q, cc_d;
  logic            rel_q, rel_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            mm_start_q, mm_start_d;
  logic            bus_owner_q, bus_owner_d;
  logic [1:0]      msel_q, msel_d, row_q, row_d, col_q, col_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wd_q, wd_d;
  logic            fd_q, fd_d;
  logic            accept, last_elem;
  logic [1:0]      rc_inc, cc_inc;

  assign in_ready  = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign accept    = in_valid && in_ready;
  assign last_elem = (rc_q == LAST) && (cc_q == LAST);

  // Row-major element counter shared by the load and readout phases; wraps after the last element.
  always_comb begin
    cc_inc = cc_q + 2'd1;
    rc_inc = rc_q;
    if (cc_q == LAST) begin
      cc_inc = 2'd0;
      rc_inc = (rc_q == LAST) ? 2'd0 : rc_q + 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rc_d        = rc_q;
    cc_d        = cc_q;
    rel_d       = rel_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mm_start_d  = mm_start_q;
    bus_owner_d = bus_owner_q;
    msel_d      = msel_q;
    row_d       = row_q;
    col_d       = col_q;
    wd_d        = wd_q;
    we_d        = 1'b0;
    fd_d        = 1'b0;
    case (state_q)
      S_IDLE: begin
        rc_d    = 2'd0;
        cc_d    = 2'd0;
        state_d = S_LOAD_A;
      end
      S_LOAD_A, S_LOAD_B: begin
        if (accept) begin
          we_d   = 1'b1;
          msel_d = (state_q == S_LOAD_B) ? 2'd1 : 2'd0;
          row_d  = rc_q;
          col_d  = cc_q;
          wd_d   = in_data;
          rc_d   = rc_inc;
          cc_d   = cc_inc;
          if (last_elem) state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_START;
        end
      end
      S_START: begin
        bus_owner_d = 1'b0;
        mm_start_d  = 1'b1;
        state_d     = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (mm_done) begin
          mm_start_d = 1'b0;
          rel_d      = 1'b0;
          state_d    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Two cycles here let the multiply controller fall back to idle before we retake the bus.
        rel_d = 1'b1;
        if (rel_q) begin
          rel_d       = 1'b0;
          bus_owner_d = 1'b1;
          rc_d        = 2'd0;
          cc_d        = 2'd0;
          state_d     = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        msel_d  = 2'd2;
        row_d   = rc_q;
        col_d   = cc_q;
        state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        out_data_d  = read_data;
        out_valid_d = 1'b1;
        state_d     = S_OUT_HOLD;
      end
      S_OUT_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rc_d        = rc_inc;
          cc_d        = cc_inc;
          if (last_elem) begin
            fd_d    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RD_ADDR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rc_q        <= 2'd0;
      cc_q        <= 2'd0;
      rel_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      mm_start_q  <= 1'b0;
      bus_owner_q <= 1'b1;
      msel_q      <= 2'd0;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      we_q        <= 1'b0;
      wd_q        <= '0;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rc_q        <= rc_d;
      cc_q        <= cc_d;
      rel_q       <= rel_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      mm_start_q  <= mm_start_d;
      bus_owner_q <= bus_owner_d;
      msel_q      <= msel_d;
      row_q       <= row_d;
      col_q       <= col_d;
      we_q        <= we_d;
      wd_q        <= wd_d;
      fd_q        <= fd_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign mm_start      = mm_start_q;
  assign bus_owner     = bus_owner_q;
  assign matrix_select = msel_q;
  assign row           = row_q;
  assign col           = col_q;
  assign write_enable  = we_q;
  assign write_data    = wd_q;
  assign frame_done    = fd_q;

endmodule

// File: tb/tb_matrix_io_sequencer.sv
// Bench for matrix_io_sequencer: memory + multiply-controller model, frame-level
// expected writes and C results, per-cycle protocol checks.
module tb_matrix_io_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       mm_start;
  logic       mm_done = 1'b0;
  logic       bus_owner;
  logic [1:0] matrix_select, row, col;
  logic       write_enable;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       frame_done;

  matrix_io_sequencer #(.N(3), .DW(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mm_start(mm_start), .mm_done(mm_done), .bus_owner(bus_owner),
    .matrix_select(matrix_select), .row(row), .col(col),
    .write_enable(write_enable), .write_data(write_data),
    .read_data(read_data), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // Shared memory: bank 0=A, 1=B, 2=C, each 9 elements row-major.
  logic [7:0] mem [3][9];
  logic [7:0] snap [2][9];

  always_comb begin
    read_data = 8'h00;
    if (matrix_select < 2'd3 && row < 2'd3 && col < 2'd3)
      read_data = mem[int'(matrix_select)][int'(row) * 3 + int'(col)];
  end

  // Multiply controller model: evaluated 2 time units after each rising edge.
  int ctl_st = 0;
  int ctl_cnt = 0;
  bit noise_en = 1'b0;

  always begin
    @(posedge clk);
    #2;
    if (write_enable && bus_owner && matrix_select < 2'd3 && row < 2'd3 && col < 2'd3)
      mem[int'(matrix_select)][int'(row) * 3 + int'(col)] = write_data;
    if (reset) begin
      ctl_st  = 0;
      mm_done = 1'b0;
    end else begin
      case (ctl_st)
        0: begin
          if (mm_start) begin
            chk("ctl_bus_owner", bus_owner, 1'b0);
            ctl_st  = 1;
            ctl_cnt = $urandom_range(0, 5);
            mm_done = 1'b0;
          end else begin
            mm_done = noise_en && ($urandom_range(0, 3) == 0);
          end
        end
        1: begin
          if (ctl_cnt == 0) begin
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++)
                  s += int'(mem[0][i * 3 + k]) * int'(mem[1][k * 3 + j]);
                mem[2][i * 3 + j] = 8'(s);
              end
            ctl_st  = 2;
            mm_done = 1'b1;
          end else begin
            ctl_cnt--;
          end
        end
        default: begin
          if (!mm_start) begin
            ctl_st  = 0;
            mm_done = 1'b0;
          end
        end
      endcase
    end
  end

  logic [13:0] exp_w [$];
  logic [7:0]  exp_c [$];
  logic [7:0]  got_c [$];

  // Per-cycle protocol checker, sampling on the falling edge.
  bit rst_p = 1'b1, acc_p = 1'b0, we_p = 1'b0, ms_p = 1'b0, md_p = 1'b0;
  bit ov_p = 1'b0, or_p = 1'b0, fd_exp = 1'b0, fall_pend = 1'b0;
  logic [7:0] od_p = 8'h00;
  int age = 0, hs_cnt = 0, w_cnt = 0, fd_cnt = 0;

  always @(negedge clk) begin
    if (rst_p) begin
      chk("reset_values",
          {in_ready, out_valid, out_data, mm_start, bus_owner, matrix_select, row, col,
           write_enable, write_data, frame_done},
          {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 1'b0});
      hs_cnt = 0; w_cnt = 0; fd_exp = 1'b0; fall_pend = 1'b0;
    end else begin
      chk("we_after_accept", write_enable, acc_p);
      if (write_enable) begin
        chk("we_bus_owner", bus_owner, 1'b1);
        if (exp_w.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
        else chk("write_addr_data", {matrix_select, row, col, write_data}, exp_w.pop_front());
        w_cnt++;
      end
      if (in_ready) chk("in_ready_phase", {bus_owner, mm_start, out_valid}, 3'b100);
      if (mm_start) chk("bus_during_start", bus_owner, 1'b0);
      if (mm_start && !ms_p) chk("start_after_last_write", {we_p, (w_cnt == 18)}, 2'b11);
      if (ms_p) chk("mm_start_vs_done", mm_start, !md_p);
      if (ms_p && !mm_start) begin
        fall_pend = 1'b1;
        age = 0;
      end else if (fall_pend) begin
        age++;
        chk("bus_return_timing", bus_owner, (age == 2));
        if (age == 2) fall_pend = 1'b0;
      end
      if (ov_p && !or_p) chk("out_hold_stable", {out_valid, out_data}, {1'b1, od_p});
      chk("frame_done_pulse", frame_done, fd_exp);
      fd_exp = 1'b0;
      if (frame_done) begin
        fd_cnt++;
        w_cnt = 0;
      end
      if (out_valid && out_ready) begin
        got_c.push_back(out_data);
        if (exp_c.size() == 0) chk("unexpected_output", 1'b1, 1'b0);
        else chk("c_element", out_data, exp_c.pop_front());
        hs_cnt++;
        if (hs_cnt == 9) begin
          fd_exp = 1'b1;
          hs_cnt = 0;
        end
      end
    end
    rst_p = reset;
    acc_p = in_valid && in_ready;
    we_p  = write_enable;
    ms_p  = mm_start;
    md_p  = mm_done;
    ov_p  = out_valid;
    or_p  = out_ready;
    od_p  = out_data;
  end

  logic [7:0] fa [9];
  logic [7:0] fb [9];
  logic [7:0] mc [9];

  // Drives one 18-element frame; inputs change 1 time unit after each rising edge.
  task automatic run_frame(input int gap_mode, input int or_mode, input bit abort);
    int idx, cyc, fd0;
    bit v, acc, ab;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int s;
        s = 0;
        for (int k = 0; k < 3; k++) s += int'(fa[i * 3 + k]) * int'(fb[k * 3 + j]);
        mc[i * 3 + j] = 8'(s);
      end
    exp_w.delete(); exp_c.delete(); got_c.delete();
    for (int e = 0; e < 18; e++)
      exp_w.push_back({(e < 9) ? 2'd0 : 2'd1, 2'((e % 9) / 3), 2'(e % 3),
                       (e < 9) ? fa[e] : fb[e - 9]});
    for (int e = 0; e < 9; e++) exp_c.push_back(mc[e]);
    fd0 = fd_cnt; idx = 0; cyc = 0; ab = 1'b0;
    while (fd_cnt == fd0 && cyc < 600 && !ab) begin
      if (idx < 18) begin
        v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
        in_valid = v;
        in_data  = v ? ((idx < 9) ? fa[idx] : fb[idx - 9]) : 8'($urandom);
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      out_ready = (or_mode == 0) ? 1'b1 : (or_mode == 1) ? (cyc % 3 == 0) : ($urandom_range(0, 2) == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (abort && mm_start) ab = 1'b1;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    if (ab) begin
      reset = 1'b1;
      out_ready = 1'b0;
      exp_w.delete(); exp_c.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_mm_start_low", mm_start, 1'b0);
      chk("abort_bus_owner_high", bus_owner, 1'b1);
      chk("abort_out_valid_low", out_valid, 1'b0);
      @(posedge clk);
      #1;
    end else begin
      chk("frame_completed", (cyc < 600), 1'b1);
      chk("handshake_count", got_c.size(), 9);
      chk("all_writes_seen", exp_w.size(), 0);
    end
  endtask

  initial begin
    for (int b = 0; b < 3; b++)
      for (int e = 0; e < 9; e++) mem[b][e] = 8'h00;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    noise_en = 1'b1;

    // Identity A times B = 1..9, gapless.
    for (int e = 0; e < 9; e++) begin
      fa[e] = (e % 4 == 0) ? 8'd1 : 8'd0;
      fb[e] = 8'(e + 1);
    end
    run_frame(0, 0, 1'b0);
    for (int e = 0; e < 9; e++) chk("model_pin_identity", mc[e], 8'(e + 1));
    for (int e = 0; e < got_c.size(); e++) chk("identity_out", got_c[e], 8'(e + 1));
    for (int b = 0; b < 2; b++)
      for (int e = 0; e < 9; e++) snap[b][e] = mem[b][e];

    // Same frame with in_valid gaps on alternate cycles.
    run_frame(1, 0, 1'b0);
    for (int b = 0; b < 2; b++)
      for (int e = 0; e < 9; e++) chk("gap_mem_matches", mem[b][e], snap[b][e]);
    for (int e = 0; e < got_c.size(); e++) chk("gap_identity_out", got_c[e], 8'(e + 1));

    // Overflow: 3*10*10 = 300 -> 44.
    for (int e = 0; e < 9; e++) begin fa[e] = 8'd10; fb[e] = 8'd10; end
    run_frame(0, 0, 1'b0);
    chk("model_pin_overflow", mc[4], 8'd44);
    for (int e = 0; e < got_c.size(); e++) chk("overflow_out", got_c[e], 8'd44);

    // Backpressure: out_ready 1-of-3 cycles, C = all 3.
    for (int e = 0; e < 9; e++) begin fa[e] = 8'd1; fb[e] = 8'd1; end
    run_frame(0, 1, 1'b0);
    chk("model_pin_ones", mc[8], 8'd3);
    for (int e = 0; e < got_c.size(); e++) chk("backpressure_out", got_c[e], 8'd3);

    // Reset while waiting for the multiply, then a clean frame.
    for (int e = 0; e < 9; e++) begin fa[e] = 8'($urandom); fb[e] = 8'($urandom); end
    run_frame(0, 0, 1'b1);
    for (int e = 0; e < 9; e++) begin fa[e] = 8'($urandom); fb[e] = 8'($urandom); end
    run_frame(0, 0, 1'b0);

    // Random frames with random gaps and backpressure.
    for (int f = 0; f < 6; f++) begin
      for (int e = 0; e < 9; e++) begin fa[e] = 8'($urandom); fb[e] = 8'($urandom); end
      run_frame(2, 2, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=t%0t expected=finish_earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
